data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width (2^ADDR_W words of 32 bits).
REQ-002 Parameter WAIT_CYCLES, default 0, stall cycles inserted per access (legal range 0..15).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 data_sram_en  input  1  access request.
REQ-006 data_sram_wen  input  4  byte-lane write enables; 4'b0000 with en=1 is a read.
REQ-007 data_sram_addr  input  32  byte address.
REQ-008 data_sram_wdata  input  32  write data, lane i = bits 8i+7:8i.
REQ-009 data_sram_rdata  output  32  registered read data.
REQ-010 stallreq_for_mem  output  1  pipeline stall request while an access is pending.

Function
REQ-011 Word index SHALL be data_sram_addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 SHALL be ignored, so higher addresses alias.
REQ-012 States SHALL be IDLE and WAIT, with a 4-bit down-counter cnt.
REQ-013 WAIT_CYCLES=0: an en=1 request in cycle T SHALL complete at the end of T; stallreq_for_mem SHALL stay 0 and the block SHALL never leave IDLE.
REQ-014 WAIT_CYCLES=N>0, IDLE with en=1 in cycle T: stallreq_for_mem=1 combinationally, cnt<=N-1, next state WAIT.
REQ-015 WAIT with en=1 and cnt!=0: stallreq_for_mem=1, cnt decrements.
REQ-016 WAIT with en=1 and cnt==0: stallreq_for_mem=0, the access completes at the end of that cycle (T+N), next state IDLE.
REQ-017 A new request SHALL be accepted no earlier than T+N+1.
REQ-018 The initiator holds en/wen/addr/wdata stable while stallreq_for_mem=1; the block SHALL sample them in the completion cycle.
REQ-019 en=0 while in WAIT (flush) SHALL abort: no write, no rdata update, stallreq_for_mem=0, next state IDLE.
REQ-020 A write completion SHALL update exactly the lanes with wen[i]=1 and leave the other lanes unchanged.
REQ-021 Read completion (wen=0) SHALL load data_sram_rdata with mem[index] at the completing edge, so the data is valid in the following cycle.
REQ-022 data_sram_rdata SHALL hold its value through writes, idle cycles and aborts.
REQ-023 A read following a write to the same word SHALL return the newly written data; there is no read-during-write hazard because accesses are sequential.
REQ-024 Memory array contents SHALL NOT be reset.

Reset
REQ-025 resetn=0 at a rising edge SHALL set state=IDLE, cnt=0 and data_sram_rdata=0.
REQ-026 While resetn=0, stallreq_for_mem SHALL be 0.
REQ-027 A reset during WAIT SHALL abort the pending access with no memory write.

Configuration
REQ-028 Macro DSRAM_ALIGN_CHECK_EN, when defined, SHALL add an output port addr_err (1 bit, reset 0).
REQ-029 With the macro, the legal wen values are 0000, 0001, 0010, 0100, 1000, 0011, 1100 and 1111.
REQ-030 With the macro, a completion with any other wen value SHALL suppress the write and pulse addr_err=1 for the cycle after completion.
REQ-031 Without the macro, the port SHALL be absent and every wen pattern SHALL be written as given.

Verification
REQ-032 WAIT_CYCLES=0: write addr=0x10, wen=1111, wdata=0xDEADBEEF; then read addr=0x10 -> rdata=0xDEADBEEF the cycle after the read; stallreq_for_mem always 0.
REQ-033 Byte lanes: word 0x20 holds 0x11223344; write wen=0100, wdata=0xAA000000 (lane 2 = 0x00) -> read returns 0x11003344; a second write wen=1000, wdata=0xAA000000 -> read returns 0xAA003344.
REQ-034 WAIT_CYCLES=3: read at T -> stallreq_for_mem=1 in T..T+2 and 0 in T+3; rdata valid at T+4; a request issued at T+4 is accepted.
REQ-035 WAIT_CYCLES=3: write issued, en dropped at T+1 -> no write (word re-read unchanged), state returns to IDLE, stallreq_for_mem=0 at T+1.
REQ-036 Reset mid-WAIT: resetn=0 at T+1 of a WAIT_CYCLES=2 write -> word unchanged, rdata=0, stallreq_for_mem=0.
REQ-037 DSRAM_ALIGN_CHECK_EN defined: write wen=0110 -> addr_err=1 for one cycle and the word is unchanged; wen=0011 -> addr_err=0 and the write occurs.

Source files
------------

// File: rtl/data_sram_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_resp_if
// Description : Bundle for the data-SRAM request/response port. The master
//               side (pipeline) drives the request and reads back the data
//               and the stall request; the slave side is the SRAM block.
//   data_sram_en      request valid
//   data_sram_wen     byte-lane write enables (0000 = read)
//   data_sram_addr    byte address
//   data_sram_wdata   write data
//   data_sram_rdata   registered read data
//   stallreq_for_mem  stall request while an access is pending
//   addr_err          illegal byte-enable pattern (DSRAM_ALIGN_CHECK_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem;
`ifdef DSRAM_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  stallreq_for_mem
`ifdef DSRAM_ALIGN_CHECK_EN
    , input addr_err
`endif
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output stallreq_for_mem
`ifdef DSRAM_ALIGN_CHECK_EN
    , output addr_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_resp
// Description : Single-port 32-bit data SRAM with byte-lane writes and a
//               programmable number of stall cycles per access.
//   clk     sole clock, rising edge
//   resetn  synchronous active-low reset
//   sram    data_sram_resp_if.slave (request in, rdata/stall out)
// Parameters  : ADDR_W      word-address width (2^ADDR_W words), 1..29
//               WAIT_CYCLES stall cycles per access, 0..15
// Option      : DSRAM_ALIGN_CHECK_EN adds addr_err and suppresses writes
//               with byte-enable patterns that are not byte/half/word lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            resetn,
  data_sram_resp_if.slave sram
);

  localparam int C_DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [C_DEPTH];
  logic [ADDR_W-1:0] w_index;
  logic              w_complete;
  logic              w_stall;
  logic              w_wen_legal;
  logic              w_write;
  logic              w_read;
  logic [31:0]       r_rdata;
  logic              unused_addr;

  // Byte offset and bits above the array size are ignored, so addresses alias.
  assign w_index     = sram.data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{sram.data_sram_addr[31:ADDR_W+2], sram.data_sram_addr[1:0]};

  generate
    if (WAIT_CYCLES == 0) begin : g_no_wait
      // Every request completes in the cycle it is presented.
      assign w_stall    = 1'b0;
      assign w_complete = resetn & sram.data_sram_en;
    end else begin : g_wait
      localparam logic [0:0] C_ST_IDLE  = 1'b0;
      localparam logic [0:0] C_ST_WAIT  = 1'b1;
      localparam logic [3:0] C_CNT_INIT = 4'(WAIT_CYCLES - 1);

      logic [0:0] r_state;
      logic [3:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_state <= C_ST_IDLE;
          r_cnt   <= 4'd0;
        end else begin
          case (r_state)
            C_ST_IDLE: begin
              if (sram.data_sram_en) begin
                r_state <= C_ST_WAIT;
                r_cnt   <= C_CNT_INIT;
              end
            end
            default: begin
              // Dropping en while waiting is a flush: abandon the access.
              if (!sram.data_sram_en || r_cnt == 4'd0) begin
                r_state <= C_ST_IDLE;
                r_cnt   <= 4'd0;
              end else begin
                r_cnt <= r_cnt - 4'd1;
              end
            end
          endcase
        end
      end

      // Stall from the first request cycle until the counter runs out; the
      // completion cycle itself is not stalled.
      assign w_stall    = resetn & sram.data_sram_en &
                          ((r_state == C_ST_IDLE) | (r_cnt != 4'd0));
      assign w_complete = resetn & sram.data_sram_en &
                          (r_state == C_ST_WAIT) & (r_cnt == 4'd0);
    end
  endgenerate

`ifdef DSRAM_ALIGN_CHECK_EN
  logic r_addr_err;

  // Only byte, aligned halfword and full-word lane groups are accepted.
  always_comb begin
    w_wen_legal = 1'b0;
    case (sram.data_sram_wen)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_wen_legal = 1'b1;
      default:                   w_wen_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_complete & ~w_wen_legal;
    end
  end

  assign sram.addr_err = r_addr_err;
`else
  assign w_wen_legal = 1'b1;
`endif

  assign w_write = w_complete & (sram.data_sram_wen != 4'b0000) & w_wen_legal;
  assign w_read  = w_complete & (sram.data_sram_wen == 4'b0000);

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      for (int i = 0; i < 4; i++) begin
        if (sram.data_sram_wen[i]) begin
          mem[w_index][8*i +: 8] <= sram.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data only changes on a read completion; it holds otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata <= 32'd0;
    end else if (w_read) begin
      r_rdata <= mem[w_index];
    end
  end

  assign sram.data_sram_rdata   = r_rdata;
  assign sram.stallreq_for_mem  = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_resp
// Description : Self-checking bench for data_sram_resp. Three instances with
//               WAIT_CYCLES = 0, 3 and 2 share the clock; each has its own
//               reset and request signals. Build with DSRAM_ALIGN_CHECK_EN
//               defined to also exercise addr_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic [2:0]  rstn;
  logic [2:0]  en;
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [2:0]  stall;
  logic [2:0]  aerr;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int W = (k == 0) ? 0 : ((k == 1) ? 3 : 2);
      data_sram_resp_if sif ();
      assign sif.data_sram_en    = en[k];
      assign sif.data_sram_wen   = wen[k];
      assign sif.data_sram_addr  = addr[k];
      assign sif.data_sram_wdata = wdata[k];
      assign rdata[k]            = sif.data_sram_rdata;
      assign stall[k]            = sif.stallreq_for_mem;
`ifdef DSRAM_ALIGN_CHECK_EN
      assign aerr[k]             = sif.addr_err;
`else
      assign aerr[k]             = 1'b0;
`endif
      data_sram_resp #(.ADDR_W(12), .WAIT_CYCLES(W)) u_dut (
        .clk    (clk),
        .resetn (rstn[k]),
        .sram   (sif)
      );
    end
  endgenerate

  function automatic int nwait(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: word array + last read value ----------
  logic [31:0] mdl     [3][4096];
  logic [31:0] last_rd [3];

  function automatic bit wen_ok(input logic [3:0] w);
`ifdef DSRAM_ALIGN_CHECK_EN
    return w inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0011, 4'b1100, 4'b1111};
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_apply(input int k, input logic [3:0] w, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] exp_rd,
                             output logic exp_err);
    int idx;
    idx = int'((a >> 2) % 4096);
    if (w == 4'b0000) begin
      last_rd[k] = mdl[k][idx];
    end else if (wen_ok(w)) begin
      for (int i = 0; i < 4; i++)
        if (w[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
    end
    exp_rd  = last_rd[k];
    exp_err = !wen_ok(w);
  endtask

  // One complete access: present, hold while stalled, drop after completion,
  // sample outputs in the following cycle. sc counts stalled cycles.
  task automatic do_access(input int k, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] d, output int sc,
                           output logic [31:0] rd, output logic er);
    sc = 0;
    @(negedge clk);
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    #1;
    while (stall[k] && sc < 20) begin
      sc++;
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    en[k] = 1'b0;
    @(negedge clk);
    rd = rdata[k];
    er = aerr[k];
  endtask

  task automatic access_chk(input string nm, input int k, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d);
    int          sc;
    logic [31:0] rd, exp_rd;
    logic        er, exp_err;
    do_access(k, w, a, d, sc, rd, er);
    model_apply(k, w, a, d, exp_rd, exp_err);
    chk({nm, "_stall_cycles"}, 32'(sc), 32'(nwait(k)));
    chk({nm, "_rdata"}, rd, exp_rd);
`ifdef DSRAM_ALIGN_CHECK_EN
    chk({nm, "_addr_err"}, {31'd0, er}, {31'd0, exp_err});
`else
    if (er) ;
    if (exp_err) ;
`endif
  endtask

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // rdata expected in the cycle after completion
  } vec_t;

  vec_t vt[11];

  initial begin
    int          sc;
    logic [31:0] rd, er_dummy_rd, e_rd;
    logic        er, e_er;

    vt[0]  = '{4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vt[1]  = '{4'b0000, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vt[2]  = '{4'b1111, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF};
    vt[3]  = '{4'b0000, 32'h0000_0020, 32'h0,         32'h1122_3344};
    vt[4]  = '{4'b0100, 32'h0000_0020, 32'hAA00_0000, 32'h1122_3344};
    vt[5]  = '{4'b0000, 32'h0000_0020, 32'h0,         32'h1100_3344};
    vt[6]  = '{4'b1000, 32'h0000_0020, 32'hAA00_0000, 32'h1100_3344};
    vt[7]  = '{4'b0000, 32'h0000_0020, 32'h0,         32'hAA00_3344};
    vt[8]  = '{4'b0000, 32'h0000_4013, 32'h0,         32'hDEAD_BEEF};
    vt[9]  = '{4'b0001, 32'h8000_4012, 32'h0000_00AB, 32'hDEAD_BEEF};
    vt[10] = '{4'b0000, 32'h0000_0010, 32'h0,         32'hDEAD_BEAB};

    rstn = 3'b000;
    en   = 3'b000;
    for (int k = 0; k < 3; k++) begin
      wen[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0; last_rd[k] = 32'd0;
    end

    // ---- reset: requests during reset must not stall, rdata clears ----
    repeat (2) @(negedge clk);
    en = 3'b111;
    #1;
    for (int k = 0; k < 3; k++) chk("reset_stall", {31'd0, stall[k]}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_rdata", rdata[k], 32'd0);
      chk("reset_addr_err", {31'd0, aerr[k]}, 32'd0);
    end
    en   = 3'b000;
    rstn = 3'b111;

    // ---- table: full word, byte lanes, aliasing on every wait setting ----
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 11; t++) begin
        do_access(k, vt[t].wen, vt[t].addr, vt[t].wdata, sc, rd, er);
        model_apply(k, vt[t].wen, vt[t].addr, vt[t].wdata, e_rd, e_er);
        chk($sformatf("vec%0d_dut%0d_rdata", t, k), rd, vt[t].exp);
        chk($sformatf("vec%0d_dut%0d_stall", t, k), 32'(sc), 32'(nwait(k)));
      end
    end

    // ---- WAIT_CYCLES=3 read timing and back-to-back acceptance ----
    @(negedge clk);
    en[1] = 1'b1; wen[1] = 4'b0000; addr[1] = 32'h20;
    for (int j = 0; j < 3; j++) begin
      #1 chk($sformatf("w3_read_stall_T%0d", j), {31'd0, stall[1]}, 32'd1);
      @(negedge clk);
    end
    #1 chk("w3_read_stall_T3", {31'd0, stall[1]}, 32'd0);
    @(negedge clk);
    chk("w3_read_rdata_T4", rdata[1], 32'hAA00_3344);
    wen[1] = 4'b1111; addr[1] = 32'h24; wdata[1] = 32'h0BAD_CAFE;
    #1 chk("w3_accept_T4", {31'd0, stall[1]}, 32'd1);
    for (int j = 1; j < 3; j++) begin
      @(negedge clk);
      #1 chk("w3_second_stall", {31'd0, stall[1]}, 32'd1);
    end
    @(negedge clk);
    #1 chk("w3_second_done", {31'd0, stall[1]}, 32'd0);
    @(posedge clk);
    #1 en[1] = 1'b0;
    model_apply(1, 4'b1111, 32'h24, 32'h0BAD_CAFE, e_rd, e_er);
    access_chk("w3_readback", 1, 4'b0000, 32'h24, 32'h0);

    // ---- WAIT_CYCLES=3 flush: no write, back to IDLE ----
    @(negedge clk);
    en[1] = 1'b1; wen[1] = 4'b1111; addr[1] = 32'h24; wdata[1] = 32'h5555_5555;
    #1 chk("flush_stall_T", {31'd0, stall[1]}, 32'd1);
    @(negedge clk);
    en[1] = 1'b0;
    #1 chk("flush_stall_T1", {31'd0, stall[1]}, 32'd0);
    access_chk("flush_readback", 1, 4'b0000, 32'h24, 32'h0);
    chk("flush_word", last_rd[1], 32'h0BAD_CAFE);

    // ---- WAIT_CYCLES=2 reset mid-wait ----
    access_chk("rstw_pre_write", 2, 4'b1111, 32'h30, 32'h1234_5678);
    access_chk("rstw_pre_read", 2, 4'b0000, 32'h30, 32'h0);
    @(negedge clk);
    en[2] = 1'b1; wen[2] = 4'b1111; addr[2] = 32'h30; wdata[2] = 32'hCAFE_F00D;
    #1 chk("rstw_stall_T", {31'd0, stall[2]}, 32'd1);
    @(negedge clk);
    rstn[2] = 1'b0;
    #1 chk("rstw_stall_in_reset", {31'd0, stall[2]}, 32'd0);
    @(negedge clk);
    chk("rstw_rdata_cleared", rdata[2], 32'd0);
    en[2] = 1'b0; rstn[2] = 1'b1; last_rd[2] = 32'd0;
    access_chk("rstw_readback", 2, 4'b0000, 32'h30, 32'h0);
    chk("rstw_word", last_rd[2], 32'h1234_5678);

`ifdef DSRAM_ALIGN_CHECK_EN
    // ---- illegal byte-enable pattern is suppressed and flagged ----
    do_access(0, 4'b0110, 32'h10, 32'hFFFF_FFFF, sc, rd, er);
    model_apply(0, 4'b0110, 32'h10, 32'hFFFF_FFFF, e_rd, e_er);
    chk("align_bad_err", {31'd0, er}, 32'd1);
    @(negedge clk);
    chk("align_bad_err_pulse", {31'd0, aerr[0]}, 32'd0);
    do_access(0, 4'b0000, 32'h10, 32'h0, sc, rd, er);
    model_apply(0, 4'b0000, 32'h10, 32'h0, e_rd, e_er);
    chk("align_bad_word", rd, 32'hDEAD_BEAB);
    do_access(0, 4'b0011, 32'h10, 32'h0000_CDEF, sc, rd, er);
    model_apply(0, 4'b0011, 32'h10, 32'h0000_CDEF, e_rd, e_er);
    chk("align_ok_err", {31'd0, er}, 32'd0);
    do_access(0, 4'b0000, 32'h10, 32'h0, sc, rd, er);
    model_apply(0, 4'b0000, 32'h10, 32'h0, e_rd, e_er);
    chk("align_ok_word", rd, 32'hDEAD_CDEF);
`endif

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++)
        access_chk("rnd_init", k, 4'b1111, 32'(i * 4), $urandom);
      for (int n = 0; n < 40; n++) begin
        logic [31:0] a;
        logic [3:0]  w;
        a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 15) * 4) |
            32'($urandom_range(0, 3));
        w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        if (nwait(k) > 0 && $urandom_range(0, 7) == 0) begin
          int j;
          j = $urandom_range(1, nwait(k));
          @(negedge clk);
          en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = $urandom;
          repeat (j) @(negedge clk);
          en[k] = 1'b0;
          #1 chk("rnd_flush_stall", {31'd0, stall[k]}, 32'd0);
        end else begin
          access_chk($sformatf("rnd_dut%0d_%0d", k, n), k, w, a, $urandom);
        end
      end
      for (int i = 0; i < 16; i++)
        access_chk("rnd_final", k, 4'b0000, 32'(i * 4), 32'h0);
    end

    er_dummy_rd = rd;
    if (er_dummy_rd == 32'd0 && e_rd == 32'd0 && e_er && er) ;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
